// File: rtl/dma_desc_sched_if.sv
// Shared DMA descriptor/status types and the scheduler-to-streamer interface.
// DMA_NUM_DESC sets the default descriptor slot count (2 when not defined).

`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 2
`endif

package dma_pkg;
   typedef struct packed {
      logic [31:0] src_addr;
      logic [31:0] num_bytes;
      logic [31:0] dst_addr;
   } s_dma_desc_t;

   typedef enum logic [1:0] {
      DMA_ERR_NONE   = 2'd0,
      DMA_AXI_RD_ERR = 2'd1,
      DMA_AXI_WR_ERR = 2'd2,
      DMA_DESC_ERR   = 2'd3
   } e_dma_err_src_t;

   typedef struct packed {
      logic           valid;
      e_dma_err_src_t src;
      logic [31:0]    addr;
   } s_dma_error_t;

   typedef struct packed {
      logic error;
      logic done;
      logic active;
   } s_dma_status_t;
endpackage

// Descriptor offer (valid/ready) plus completion/error reports from the streamer.
interface dma_desc_sched_if;
   import dma_pkg::*;

   logic         desc_valid_o;
   s_dma_desc_t  desc_o;
   logic         desc_ready_i;
   logic         xfer_done_i;
   s_dma_error_t xfer_err_i;

   modport master (
      output desc_valid_o,
      output desc_o,
      input  desc_ready_i,
      input  xfer_done_i,
      input  xfer_err_i
   );

   modport slave (
      input  desc_valid_o,
      input  desc_o,
      output desc_ready_i,
      output xfer_done_i,
      output xfer_err_i
   );
endinterface

// File: rtl/dma_desc_sched.sv
// Venus DMA descriptor scheduler: holds NUM_DESC descriptor slots, issues
// pending slots round-robin to the streamer and aggregates status/error.
// Optional feature macro: DMA_DESC_ERR_HALT_EN (an error flushes all pending
// slots instead of dropping only the failing one).

module dma_desc_sched
   import dma_pkg::*;
#(
   parameter int unsigned NUM_DESC = `DMA_NUM_DESC,
   parameter int unsigned SLOT_W   = $clog2(NUM_DESC)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                desc_wr_i,
   input  logic [SLOT_W-1:0]   desc_wr_slot_i,
   input  s_dma_desc_t         desc_wr_data_i,
   output logic                desc_wr_reject_o,
   input  logic                clear_i,
   dma_desc_sched_if.master    strm,
   output s_dma_status_t       status_o,
   output s_dma_error_t        err_o,
   output logic [NUM_DESC-1:0] pending_o,
   output logic [NUM_DESC-1:0] done_mask_o,
   output logic [SLOT_W-1:0]   cur_slot_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } e_state_t;

   e_state_t            state;
   s_dma_desc_t         desc_mem [NUM_DESC];
   logic [SLOT_W-1:0]   rr_ptr;

   logic                wr_in_range;
   logic                wr_busy;
   logic                wr_acc;
   logic                wr_zero;
   logic                wait_err;
   logic                wait_done;
   logic                wait_end;
   logic                pick_found;
   logic [SLOT_W-1:0]   pick_slot;
   logic [SLOT_W-1:0]   cur_inc;
   logic                busy_nxt;
   logic                error_nxt;
   logic                done_set;
   logic [NUM_DESC-1:0] pending_nxt;
   logic [NUM_DESC-1:0] done_mask_nxt;

   // Write acceptance and completion-event decode
   always_comb begin
      wr_in_range = 32'(desc_wr_slot_i) < NUM_DESC;
      wr_busy     = pending_o[desc_wr_slot_i] |
                    ((state != IDLE) & (desc_wr_slot_i == cur_slot_o));
      wr_acc      = desc_wr_i & wr_in_range & ~wr_busy;
      wr_zero     = (desc_wr_data_i.num_bytes == 32'd0);
      wait_err    = (state == WAIT) & strm.xfer_err_i.valid;
      wait_done   = (state == WAIT) & strm.xfer_done_i & ~strm.xfer_err_i.valid;
      wait_end    = wait_err | wait_done;
      cur_inc     = (32'(cur_slot_o) == NUM_DESC - 1) ? '0 : cur_slot_o + SLOT_W'(1);
   end

   // Round-robin search: first pending slot at or after rr_ptr, wrapping
   always_comb begin
      int unsigned k;
      k          = 0;
      pick_found = 1'b0;
      pick_slot  = '0;
      for (int unsigned i = 0; i < NUM_DESC; i++) begin
         k = 32'(rr_ptr) + i;
         if (k >= NUM_DESC) k = k - NUM_DESC;
         if (!pick_found && pending_o[SLOT_W'(k)]) begin
            pick_found = 1'b1;
            pick_slot  = SLOT_W'(k);
         end
      end
   end

   // Next pending/done_mask; a write to a slot overrides clear for that bit
   always_comb begin
      pending_nxt   = pending_o;
      done_mask_nxt = done_mask_o;
      if (clear_i) done_mask_nxt = '0;
      if (wait_err) begin
`ifdef DMA_DESC_ERR_HALT_EN
         pending_nxt = '0;
`else
         pending_nxt[cur_slot_o] = 1'b0;
`endif
      end
      if (wait_done) begin
         pending_nxt[cur_slot_o]   = 1'b0;
         done_mask_nxt[cur_slot_o] = 1'b1;
      end
      if (wr_acc) begin
         if (wr_zero) begin
            done_mask_nxt[desc_wr_slot_i] = 1'b1;
         end else begin
            pending_nxt[desc_wr_slot_i]   = 1'b1;
            done_mask_nxt[desc_wr_slot_i] = 1'b0;
         end
      end
   end

   // Next-cycle activity and sticky status set conditions
   always_comb begin
      case (state)
         IDLE:    busy_nxt = pick_found;
         ISSUE:   busy_nxt = 1'b1;
         WAIT:    busy_nxt = ~wait_end;
         default: busy_nxt = 1'b0;
      endcase
      error_nxt = wait_err | (status_o.error & ~clear_i);
      done_set  = (|pending_o) & ~(|pending_nxt) & ~error_nxt;
   end

   // Scheduler FSM: latch the picked descriptor, offer it, wait for the result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         strm.desc_valid_o <= 1'b0;
         strm.desc_o       <= '0;
         cur_slot_o        <= '0;
         rr_ptr            <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state             <= ISSUE;
                  strm.desc_valid_o <= 1'b1;
                  strm.desc_o       <= desc_mem[pick_slot];
                  cur_slot_o        <= pick_slot;
               end
            end
            ISSUE: begin
               if (strm.desc_ready_i) begin
                  state             <= WAIT;
                  strm.desc_valid_o <= 1'b0;
               end
            end
            WAIT: begin
               if (wait_end) begin
                  state  <= IDLE;
                  rr_ptr <= cur_inc;
               end
            end
            default: begin
               state             <= IDLE;
               strm.desc_valid_o <= 1'b0;
            end
         endcase
      end
   end

   // Descriptor storage; zero-length writes store nothing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_DESC; i++) desc_mem[i] <= '0;
      end else if (wr_acc && !wr_zero) begin
         desc_mem[desc_wr_slot_i] <= desc_wr_data_i;
      end
   end

   // Slot bookkeeping, reject pulse, status and first-error capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_o        <= '0;
         done_mask_o      <= '0;
         desc_wr_reject_o <= 1'b0;
         status_o         <= '0;
         err_o            <= '0;
      end else begin
         pending_o        <= pending_nxt;
         done_mask_o      <= done_mask_nxt;
         desc_wr_reject_o <= desc_wr_i & ~wr_acc;
         status_o.active  <= busy_nxt | (|pending_nxt);
         status_o.error   <= error_nxt;
         status_o.done    <= done_set | (status_o.done & ~clear_i);
         if (wait_err && (!err_o.valid || clear_i)) begin
            err_o <= strm.xfer_err_i;
         end else if (clear_i) begin
            err_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed self-checking bench for dma_desc_sched (2 slots).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_dma_desc_sched;
   import dma_pkg::*;

   localparam int unsigned NUM_DESC = 2;
   localparam int unsigned SLOT_W   = 1;

   logic                clk = 1'b0;
   logic                rst;
   logic                desc_wr_i;
   logic [SLOT_W-1:0]   desc_wr_slot_i;
   s_dma_desc_t         desc_wr_data_i;
   logic                desc_wr_reject_o;
   logic                clear_i;
   s_dma_status_t       status_o;
   s_dma_error_t        err_o;
   logic [NUM_DESC-1:0] pending_o;
   logic [NUM_DESC-1:0] done_mask_o;
   logic [SLOT_W-1:0]   cur_slot_o;

   dma_desc_sched_if bus ();

   dma_desc_sched #(.NUM_DESC(NUM_DESC), .SLOT_W(SLOT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .desc_wr_i        (desc_wr_i),
      .desc_wr_slot_i   (desc_wr_slot_i),
      .desc_wr_data_i   (desc_wr_data_i),
      .desc_wr_reject_o (desc_wr_reject_o),
      .clear_i          (clear_i),
      .strm             (bus),
      .status_o         (status_o),
      .err_o            (err_o),
      .pending_o        (pending_o),
      .done_mask_o      (done_mask_o),
      .cur_slot_o       (cur_slot_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   s_dma_desc_t  d1 = '{src_addr: 32'h1000, num_bytes: 32'h40, dst_addr: 32'h2000};
   s_dma_desc_t  da = '{src_addr: 32'hA000, num_bytes: 32'h10, dst_addr: 32'hA800};
   s_dma_desc_t  db = '{src_addr: 32'hB000, num_bytes: 32'h20, dst_addr: 32'hB800};
   s_dma_desc_t  dc = '{src_addr: 32'hC000, num_bytes: 32'h30, dst_addr: 32'hC800};
   s_dma_desc_t  dd = '{src_addr: 32'hD000, num_bytes: 32'h44, dst_addr: 32'hD800};
   s_dma_desc_t  de = '{src_addr: 32'hE000, num_bytes: 32'h55, dst_addr: 32'hE800};
   s_dma_desc_t  dz = '{src_addr: 32'hF000, num_bytes: 32'h0,  dst_addr: 32'hF800};
   s_dma_error_t e1 = '{valid: 1'b1, src: DMA_AXI_WR_ERR, addr: 32'h3000};
   s_dma_error_t e2 = '{valid: 1'b1, src: DMA_AXI_RD_ERR, addr: 32'h4000};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [SLOT_W-1:0] slot, input s_dma_desc_t d);
      desc_wr_i      = 1'b1;
      desc_wr_slot_i = slot;
      desc_wr_data_i = d;
      tick();
      desc_wr_i      = 1'b0;
   endtask

   task automatic hs();
      bus.desc_ready_i = 1'b1;
      tick();
      bus.desc_ready_i = 1'b0;
   endtask

   task automatic pulse_done();
      bus.xfer_done_i = 1'b1;
      tick();
      bus.xfer_done_i = 1'b0;
   endtask

   task automatic pulse_err(input s_dma_error_t e, input logic with_done);
      bus.xfer_err_i  = e;
      bus.xfer_done_i = with_done;
      tick();
      bus.xfer_err_i  = '0;
      bus.xfer_done_i = 1'b0;
   endtask

   task automatic clr();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   initial begin
      rst              = 1'b1;
      desc_wr_i        = 1'b0;
      desc_wr_slot_i   = '0;
      desc_wr_data_i   = '0;
      clear_i          = 1'b0;
      bus.desc_ready_i = 1'b0;
      bus.xfer_done_i  = 1'b0;
      bus.xfer_err_i   = '0;
      repeat (2) tick();

      // reset values
      check("rst_valid",   128'(bus.desc_valid_o), 128'(0));
      check("rst_desc",    128'(bus.desc_o),       128'(0));
      check("rst_status",  128'(status_o),         128'(0));
      check("rst_err",     128'(err_o),            128'(0));
      check("rst_pending", 128'(pending_o),        128'(0));
      check("rst_dmask",   128'(done_mask_o),      128'(0));
      check("rst_reject",  128'(desc_wr_reject_o), 128'(0));
      check("rst_cur",     128'(cur_slot_o),       128'(0));
      rst = 1'b0;
      tick();

      // single descriptor: pending at t+1, valid at t+2, done sets sticky status
      wr(1'b0, d1);
      check("t1_pending",  128'(pending_o),        128'(2'b01));
      check("t1_active",   128'(status_o),         128'(3'b001));
      check("t1_valid_t1", 128'(bus.desc_valid_o), 128'(0));
      tick();
      check("t1_valid_t2", 128'(bus.desc_valid_o), 128'(1));
      check("t1_desc",     128'(bus.desc_o),       128'(d1));
      check("t1_cur",      128'(cur_slot_o),       128'(0));
      hs();
      check("t1_wait_vld", 128'(bus.desc_valid_o), 128'(0));
      check("t1_wait_st",  128'(status_o),         128'(3'b001));
      pulse_done();
      check("t1_dmask",    128'(done_mask_o),      128'(2'b01));
      check("t1_pend0",    128'(pending_o),        128'(0));
      check("t1_status",   128'(status_o),         128'(3'b010));

      // round-robin order and wrap back to slot0
      clr();
      check("t2_clr_st",   128'(status_o),         128'(0));
      check("t2_clr_dm",   128'(done_mask_o),      128'(0));
      wr(1'b0, da);
      wr(1'b1, db);
      check("t2_valid_a",  128'(bus.desc_valid_o), 128'(1));
      check("t2_desc_a",   128'(bus.desc_o),       128'(da));
      check("t2_pend11",   128'(pending_o),        128'(2'b11));
      hs();
      pulse_done();
      check("t2_d1_vld",   128'(bus.desc_valid_o), 128'(0));
      tick();
      check("t2_d2_vld",   128'(bus.desc_valid_o), 128'(1));
      check("t2_desc_b",   128'(bus.desc_o),       128'(db));
      check("t2_cur_b",    128'(cur_slot_o),       128'(1));
      hs();
      wr(1'b0, dc);
      check("t2_wr_ok",    128'(desc_wr_reject_o), 128'(0));
      check("t2_pend_c",   128'(pending_o),        128'(2'b11));
      pulse_done();
      tick();
      check("t2_desc_c",   128'(bus.desc_o),       128'(dc));
      check("t2_cur_c",    128'(cur_slot_o),       128'(0));
      hs();
      pulse_done();
      check("t2_dmask",    128'(done_mask_o),      128'(2'b11));
      check("t2_status",   128'(status_o),         128'(3'b010));

      // refused writes leave stored descriptor unchanged
      clr();
      wr(1'b1, dc);
      wr(1'b0, dd);
      wr(1'b0, de);
      check("t3_rej_pend", 128'(desc_wr_reject_o), 128'(1));
      wr(1'b1, de);
      check("t3_rej_cur",  128'(desc_wr_reject_o), 128'(1));
      tick();
      check("t3_rej_pulse",128'(desc_wr_reject_o), 128'(0));
      check("t3_desc_c",   128'(bus.desc_o),       128'(dc));
      hs();
      pulse_done();
      tick();
      check("t3_desc_d",   128'(bus.desc_o),       128'(dd));
      hs();
      pulse_done();
      check("t3_pend0",    128'(pending_o),        128'(0));

      // zero-length write completes immediately and is never issued
      clr();
      wr(1'b1, dz);
      check("t3_z_rej",    128'(desc_wr_reject_o), 128'(0));
      check("t3_z_dmask",  128'(done_mask_o),      128'(2'b10));
      check("t3_z_pend",   128'(pending_o),        128'(0));
      repeat (3) tick();
      check("t3_z_vld",    128'(bus.desc_valid_o), 128'(0));

      // error on first of two pending slots
      clr();
      wr(1'b0, da);
      wr(1'b1, db);
      check("t4_cur0",     128'(cur_slot_o),       128'(0));
      hs();
      pulse_err(e1, 1'b0);
      check("t4_err",      128'(err_o),            128'(e1));
`ifdef DMA_DESC_ERR_HALT_EN
      check("t4_pend",     128'(pending_o),        128'(0));
      check("t4_status",   128'(status_o),         128'(3'b100));
      repeat (3) tick();
      check("t4_no_issue", 128'(bus.desc_valid_o), 128'(0));
      check("t4_dmask",    128'(done_mask_o),      128'(0));
`else
      check("t4_pend",     128'(pending_o),        128'(2'b10));
      check("t4_status",   128'(status_o),         128'(3'b101));
      tick();
      check("t4_issue1",   128'(bus.desc_valid_o), 128'(1));
      check("t4_desc_b",   128'(bus.desc_o),       128'(db));
      hs();
      pulse_done();
      check("t4_status2",  128'(status_o),         128'(3'b100));
      check("t4_dmask",    128'(done_mask_o),      128'(2'b10));
`endif

      // same-cycle done and error: error wins
      clr();
      check("t5_clr_err",  128'(err_o),            128'(0));
      wr(1'b0, da);
      tick();
      check("t5_vld",      128'(bus.desc_valid_o), 128'(1));
      hs();
      pulse_err(e2, 1'b1);
      check("t5_err",      128'(err_o),            128'(e2));
      check("t5_dmask",    128'(done_mask_o),      128'(0));
      check("t5_status",   128'(status_o),         128'(3'b100));

      // clear during WAIT: sticky bits cleared, transfer still completes
      wr(1'b1, db);
      tick();
      hs();
      clr();
      check("t5_wclr_st",  128'(status_o),         128'(3'b001));
      check("t5_wclr_err", 128'(err_o),            128'(0));
      pulse_done();
      check("t5_wdone_dm", 128'(done_mask_o),      128'(2'b10));
      check("t5_wdone_st", 128'(status_o),         128'(3'b010));

      // pulses outside WAIT are ignored
      pulse_err(e1, 1'b1);
      check("t5_ign_err",  128'(err_o),            128'(0));
      check("t5_ign_st",   128'(status_o),         128'(3'b010));

      // asynchronous reset while offering a descriptor
      wr(1'b0, da);
      tick();
      check("t6_issue",    128'(bus.desc_valid_o), 128'(1));
      #1 rst = 1'b1;
      #1;
      check("t6_vld",      128'(bus.desc_valid_o), 128'(0));
      check("t6_desc",     128'(bus.desc_o),       128'(0));
      check("t6_pend",     128'(pending_o),        128'(0));
      check("t6_status",   128'(status_o),         128'(0));
      check("t6_dmask",    128'(done_mask_o),      128'(0));
      check("t6_cur",      128'(cur_slot_o),       128'(0));
      tick();
      rst = 1'b0;
      repeat (2) tick();
      check("t6_idle",     128'(bus.desc_valid_o), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
